// File: rtl/tinyalu_rtl_pkg.sv
// Shared opcode encodings, FSM state type and counter width for the TinyALU
// responder RTL.
package tinyalu_rtl_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  // Wide enough for MUL_LAT-1 with MUL_LAT up to 8.
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_WAIT_LOW
  } state_t;

endpackage

// File: rtl/tinyalu_mul_pipe.sv
// Unsigned 8x8 multiplier pipeline for the TinyALU.
// The product is formed when valid_in is high and then shifts through
// LAT-1 registers. The consumer's result register is the final stage, so
// the product is in that register LAT edges after valid_in.
module tinyalu_mul_pipe #(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        valid_in,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        valid_out,
  output logic [15:0] product
);

  localparam int N = LAT - 1;

  logic [N-1:0] vld_q;
  logic [15:0]  data_q [N];

  // Valid shift register. The synchronous clear drops any product in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every stage
    // samples its predecessor's value from before this edge.
    if (!clr_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= valid_in;
      for (int i = 1; i < N; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Data shift register. Stage 0 loads only on valid_in, so idle operands,
  // including X, never enter the pipe.
  always_ff @(posedge clk) begin
    // NOTE: the data stages have no reset. valid gates every use of the data,
    // so a reset here would only add cost.
    if (valid_in) begin
      data_q[0] <= 16'(a) * 16'(b);
    end
    for (int i = 1; i < N; i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  assign valid_out = vld_q[N-1];
  assign product   = data_q[N-1];

endmodule

// File: rtl/tinyalu_core.sv
// TinyALU responder. An operation is accepted on a start handshake.
// add, and, xor and nop finish at the accept edge. mul goes through
// tinyalu_mul_pipe and finishes MUL_LAT-1 edges after the accept edge.
// done is a one-cycle pulse. result holds the last completed value.
// MUL_LAT must be in the range 2..8.
module tinyalu_core #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result,
  output logic        busy
);

  import tinyalu_rtl_pkg::*;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_d, busy_d;
  logic [15:0]        result_d;
  logic               mul_start, mul_valid;
  logic [15:0]        mul_product;

  tinyalu_mul_pipe #(
    .LAT (MUL_LAT)
  ) u_mul_pipe (
    .clk       (clk),
    .clr_n     (rst_n),
    .valid_in  (mul_start),
    .a         (A),
    .b         (B),
    .valid_out (mul_valid),
    .product   (mul_product)
  );

  // Next-state, output and counter decode.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    busy_d    = busy;
    result_d  = result;
    mul_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT_LOW;
          done_d  = 1'b1;
          case (op)
            OP_ADD: result_d = {7'b0, {1'b0, A} + {1'b0, B}};
            OP_AND: result_d = {8'b0, A & B};
            OP_XOR: result_d = {8'b0, A ^ B};
            OP_MUL: begin
              state_d   = S_MUL;
              done_d    = 1'b0;
              busy_d    = 1'b1;
              cnt_d     = CNT_W'(MUL_LAT - 1);
              mul_start = 1'b1;
            end
            default: ;  // nop and illegal opcodes leave result unchanged
          endcase
        end
      end
      S_MUL: begin
        cnt_d = cnt_q - 1'b1;
        if (mul_valid) begin
          state_d  = S_WAIT_LOW;
          result_d = mul_product;
          done_d   = 1'b1;
        end
      end
      S_WAIT_LOW: begin
        busy_d = 1'b0;
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done    <= done_d;
      busy    <= busy_d;
      result  <= result_d;
    end
  end

  // The local countdown and the pipe's valid_out must agree on when mul ends.
  a_cnt_matches_pipe: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_MUL) |-> (mul_valid == (cnt_q == CNT_W'(1))));

  // done is a single-cycle pulse.
  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

endmodule

// File: tb/tb_tinyalu_core.sv
// Testbench for tinyalu_core. A table of vectors is applied through a
// start/done driver task, followed by hand-written sequences for reset,
// held start, early start drop and reset while a mul is in flight.
// Expected results go into a scoreboard queue. A monitor pops one entry
// per done pulse.
module tb_tinyalu_core;

  localparam int         MUL_LAT = 3;
  localparam logic [2:0] T_NOP = 3'b000;
  localparam logic [2:0] T_ADD = 3'b001;
  localparam logic [2:0] T_AND = 3'b010;
  localparam logic [2:0] T_XOR = 3'b011;
  localparam logic [2:0] T_MUL = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  A, B;
  logic [2:0]  op;
  logic        start;
  logic        done;
  logic [15:0] result;
  logic        busy;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] sb_q [$];
  logic        prev_done = 1'b0;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs [12];

  tinyalu_core #(.MUL_LAT(MUL_LAT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .op     (op),
    .start  (start),
    .done   (done),
    .result (result),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each done pops one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      check("done_not_back_to_back", {31'b0, prev_done}, 32'd0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_done: result=%0h with empty scoreboard at %0t", result, $time);
      end else begin
        check("sb_result", {16'b0, result}, {16'b0, sb_q.pop_front()});
      end
    end
    prev_done = (rst_n === 1'b1) ? done : 1'b0;
  end

  // Drives one operation and checks done latency, busy width, pulse width
  // and that result is held. hold keeps start high for extra cycles after
  // done. drop_early drops start one cycle after the accept edge.
  task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp_res, input int exp_lat,
                       input int hold, input bit drop_early);
    int lat;
    int busy_cnt;
    int exp_busy;
    lat      = 0;
    busy_cnt = 0;
    exp_busy = (o == T_MUL) ? exp_lat : 0;
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    sb_q.push_back(exp_res);
    @(posedge clk);  // accept edge
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Operand and opcode changes after the accept edge must be ignored.
        A  = 8'($urandom);
        B  = 8'($urandom);
        op = 3'($urandom);
        if (drop_early) start = 1'b0;
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
    check("done_latency", lat, exp_lat);
    check("busy_cycles", busy_cnt, exp_busy);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("held_start_no_done", {31'b0, done}, 32'd0);
      check("held_start_not_busy", {31'b0, busy}, 32'd0);
    end
    start = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    @(negedge clk);
    check("done_width_1", {31'b0, done}, 32'd0);
    check("busy_cleared", {31'b0, busy}, 32'd0);
    check("result_held", {16'b0, result}, {16'b0, exp_res});
  endtask

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    vecs[0]  = '{T_ADD,  8'hFF, 8'h01, 16'h0100, 1};
    vecs[1]  = '{T_MUL,  8'hFF, 8'hFF, 16'hFE01, MUL_LAT};
    vecs[2]  = '{T_XOR,  8'hA5, 8'h0F, 16'h00AA, 1};
    vecs[3]  = '{T_NOP,  8'h12, 8'h34, 16'h00AA, 1};
    vecs[4]  = '{3'b110, 8'h56, 8'h78, 16'h00AA, 1};
    vecs[5]  = '{T_ADD,  8'hFF, 8'hFF, 16'h01FE, 1};
    vecs[6]  = '{T_AND,  8'hAA, 8'h0F, 16'h000A, 1};
    vecs[7]  = '{T_MUL,  8'h0C, 8'h0D, 16'h009C, MUL_LAT};
    vecs[8]  = '{3'b111, 8'h11, 8'h22, 16'h009C, 1};
    vecs[9]  = '{T_MUL,  8'h00, 8'hFF, 16'h0000, MUL_LAT};
    vecs[10] = '{T_ADD,  8'h80, 8'h80, 16'h0100, 1};
    vecs[11] = '{T_XOR,  8'hFF, 8'hFF, 16'h0000, 1};

    // Reset held for three cycles with a live add request.
    rst_n = 1'b0; start = 1'b1; op = T_ADD; A = 8'h5A; B = 8'h3C;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_result", {16'b0, result}, 32'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;

    // Table-driven operations.
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat, 0, 1'b0);
    end

    // start held for 5 cycles after an and: one done only, then a fresh and.
    do_op(T_AND, 8'h0F, 8'h33, 16'h0003, 1, 5, 1'b0);
    do_op(T_AND, 8'hF0, 8'h3C, 16'h0030, 1, 0, 1'b0);

    // start dropped right after a mul is accepted: mul still completes.
    do_op(T_MUL, 8'h10, 8'h10, 16'h0100, MUL_LAT, 0, 1'b1);

    // Reset one edge after a mul is accepted: the mul never reports done.
    @(negedge clk);
    op = T_MUL; A = 8'h07; B = 8'h09; start = 1'b1;
    @(posedge clk);  // accept edge
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mul_reset_busy", {31'b0, busy}, 32'd0);
    check("mul_reset_result", {16'b0, result}, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("discarded_mul_no_done", seen, 0);
    do_op(T_ADD, 8'h02, 8'h03, 16'h0005, 1, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
